// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Central hazard and sequencing controller for a 5-stage RISC-V pipeline.
// It drives the enable and flush controls of the PC and of the IF/ID, ID/EX,
// EX/MEM and MEM/WB pipeline registers. Three conditions are resolved:
//   * data-memory wait states  -> freeze the front of the pipe, bubble MEM/WB
//   * taken branch/jump in EX  -> redirect the PC, flush IF/ID and ID/EX,
//                                 then hold the IF/ID flush for FLUSH_CYCLES
//   * load-use hazard          -> one-cycle stall with an ID/EX bubble
// Priority, highest first: memory wait, branch redirect, load-use.
// A watchdog raises a sticky error when a memory access waits MEM_TIMEOUT
// consecutive cycles.
//
// Parameters:
//   FLUSH_CYCLES  extra IF/ID flush cycles after a redirect (0..7)
//   MEM_TIMEOUT   consecutive wait cycles before o_mem_timeout sets (1..65535)
//
// Ports:
//   clk              clock, all state updates on posedge
//   rst              asynchronous active-low reset
//   i_id_rs1_num     rs1 index of the instruction in ID
//   i_id_rs2_num     rs2 index of the instruction in ID
//   i_id_uses_rs1    ID instruction reads rs1
//   i_id_uses_rs2    ID instruction reads rs2
//   i_ex_opcode      opcode held in ID/EX
//   i_ex_rd_num      rd held in ID/EX
//   i_ex_br_taken    EX resolved a taken branch/JAL/JALR this cycle
//   i_dmem_req       MEM stage is issuing a load/store
//   i_dmem_ready     data memory completes the access this cycle
//   o_pc_en          PC update enable
//   o_pc_sel         1 = EX branch target, 0 = PC+4
//   o_if_id_en       IF/ID load enable
//   o_if_id_flush    IF/ID loads a NOP
//   o_id_ex_en       ID/EX load enable
//   o_id_ex_flush    ID/EX loads a bubble
//   o_ex_mem_en      EX/MEM load enable
//   o_mem_wb_flush   MEM/WB loads a bubble
//   o_mem_timeout    sticky watchdog error
//
// Optional feature (macro PIPE_HAZARD_CTRL_PERF_EN):
//   adds wrapping 32-bit performance counters o_stall_cnt (load-use stall
//   cycles), o_flush_cnt (redirect cycles) and o_wait_cnt (memory wait
//   cycles). With the macro undefined these ports do not exist.
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_id_rs1_num,
    input  logic [4:0]  i_id_rs2_num,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic [6:0]  i_ex_opcode,
    input  logic [4:0]  i_ex_rd_num,
    input  logic        i_ex_br_taken,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic        o_if_id_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_en,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_flush,
    output logic        o_mem_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_wait_cnt
`endif
);

    localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
    localparam logic [2:0]  FLUSH_LOAD  = 3'(FLUSH_CYCLES);
    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_flush_cnt;
    logic [2:0]  w_flush_cnt_next;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_inc;
    logic        r_timeout;

    logic w_mem_wait;
    logic w_mem_exit;
    logic w_redirect;
    logic w_hazard_match;
    logic w_load_use;

    // Event decode. A branch is not acted on while memory is stalled, nor on
    // the cycle MEM_WAIT is left: EX re-presents it on the following cycle.
    assign w_mem_wait     = i_dmem_req & ~i_dmem_ready;
    assign w_mem_exit     = (r_state == S_MEM_WAIT) & ~w_mem_wait;
    assign w_redirect     = i_ex_br_taken & ~w_mem_wait & (r_state != S_MEM_WAIT);
    assign w_hazard_match = (i_ex_opcode == OPC_LOAD) && (i_ex_rd_num != 5'd0) &&
                            ((i_id_uses_rs1 && (i_ex_rd_num == i_id_rs1_num)) ||
                             (i_id_uses_rs2 && (i_ex_rd_num == i_id_rs2_num)));
    // Load-use is only meaningful in RUN; in FLUSH the ID stage holds a NOP.
    assign w_load_use     = (r_state == S_RUN) & ~w_mem_wait & ~i_ex_br_taken &
                            w_hazard_match;

    // Saturating increment for the watchdog.
    assign w_wait_inc = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

    // Next-state and flush-counter logic. A memory wait keeps any pending
    // flush count so the post-redirect flush resumes once memory completes.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        if (w_mem_wait) begin
            w_state_next = S_MEM_WAIT;
        end else if (r_state == S_MEM_WAIT) begin
            w_state_next = (r_flush_cnt != 3'd0) ? S_FLUSH : S_RUN;
        end else if (w_redirect) begin
            w_flush_cnt_next = FLUSH_LOAD;
            w_state_next     = (FLUSH_LOAD != 3'd0) ? S_FLUSH : S_RUN;
        end else if (r_state == S_FLUSH) begin
            if (r_flush_cnt <= 3'd1) begin
                w_flush_cnt_next = 3'd0;
                w_state_next     = S_RUN;
            end else begin
                w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
        end else begin
            w_state_next = S_RUN;
        end
    end

    // Output decode. Reset is folded in combinationally so the pipeline is
    // frozen and flushed the instant rst falls, without waiting for a clock.
    always_comb begin
        o_pc_en        = 1'b1;
        o_pc_sel       = 1'b0;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_flush = 1'b0;
        if (!rst) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_mem_wb_flush = 1'b1;
        end else if (w_mem_wait) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
        end else if (w_mem_exit) begin
            o_pc_en        = 1'b1;
        end else if (w_redirect) begin
            o_pc_sel       = 1'b1;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end else if (r_state == S_FLUSH) begin
            o_if_id_flush  = 1'b1;
        end else if (w_load_use) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_flush  = 1'b1;
        end
    end

    assign o_mem_timeout = rst & r_timeout;

    // State, flush counter and watchdog registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 3'd0;
            r_wait_cnt  <= 16'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            if (w_mem_wait) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc >= TIMEOUT_LIM) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= 16'd0;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_evt_cnt;
    logic [31:0] r_wait_evt_cnt;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt     <= 32'd0;
            r_flush_evt_cnt <= 32'd0;
            r_wait_evt_cnt  <= 32'd0;
        end else begin
            if (w_load_use) r_stall_cnt     <= r_stall_cnt + 32'd1;
            if (w_redirect) r_flush_evt_cnt <= r_flush_evt_cnt + 32'd1;
            if (w_mem_wait) r_wait_evt_cnt  <= r_wait_evt_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_evt_cnt;
    assign o_wait_cnt  = r_wait_evt_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Directed-vector bench for pipe_hazard_ctrl (FLUSH_CYCLES=1, MEM_TIMEOUT=4).
// The stimulus process drives one vector per cycle shortly after posedge and
// pushes the hand-computed expected output vector into a queue; a separate
// monitor pops and compares on each negedge.
// Output vector order:
//   {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//    ex_mem_en, mem_wb_flush, mem_timeout}
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_ALU  = 7'b0110011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    localparam logic [8:0] E_DEF    = 9'b101010100;
    localparam logic [8:0] E_DEF_TO = 9'b101010101;
    localparam logic [8:0] E_RST    = 9'b000101010;
    localparam logic [8:0] E_LU     = 9'b000011100;
    localparam logic [8:0] E_BR     = 9'b111111100;
    localparam logic [8:0] E_FL     = 9'b101110100;
    localparam logic [8:0] E_MW     = 9'b000000010;
    localparam logic [8:0] E_MW_TO  = 9'b000000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_num, id_rs2_num;
    logic       id_uses_rs1, id_uses_rs2;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd_num;
    logic       ex_br_taken, dmem_req, dmem_ready;
    logic       pc_en, pc_sel, if_id_en, if_id_flush;
    logic       id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    logic [8:0] actual;
    assign actual = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en,
                     id_ex_flush, ex_mem_en, mem_wb_flush, mem_timeout};

    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (1),
        .MEM_TIMEOUT  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_id_rs1_num   (id_rs1_num),
        .i_id_rs2_num   (id_rs2_num),
        .i_id_uses_rs1  (id_uses_rs1),
        .i_id_uses_rs2  (id_uses_rs2),
        .i_ex_opcode    (ex_opcode),
        .i_ex_rd_num    (ex_rd_num),
        .i_ex_br_taken  (ex_br_taken),
        .i_dmem_req     (dmem_req),
        .i_dmem_ready   (dmem_ready),
        .o_pc_en        (pc_en),
        .o_pc_sel       (pc_sel),
        .o_if_id_en     (if_id_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_en     (id_ex_en),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_flush (mem_wb_flush),
        .o_mem_timeout  (mem_timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt),
        .o_wait_cnt     (wait_cnt)
`endif
    );

    // Compare one popped expectation against the live outputs.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (actual !== e.exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", e.name, actual, e.exp);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one pop per negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    task automatic pushExpect(input string name, input logic [8:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    // Drive one cycle of pipeline inputs and record the expected response.
    task automatic applyStimulus(input string name, input logic [8:0] exp,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [6:0] op, input logic [4:0] rd,
                                 input logic br, input logic req,
                                 input logic rdy);
        @(posedge clk);
        #1;
        id_rs1_num  = rs1;
        id_rs2_num  = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_opcode   = op;
        ex_rd_num   = rd;
        ex_br_taken = br;
        dmem_req    = req;
        dmem_ready  = rdy;
        pushExpect(name, exp);
    endtask

    task automatic idleCycle(input string name, input logic [8:0] exp);
        applyStimulus(name, exp, 5'd1, 5'd2, 1'b1, 1'b1, OPC_ALU, 5'd3,
                      1'b0, 1'b0, 1'b0);
    endtask

    task automatic memCycle(input string name, input logic [8:0] exp,
                            input logic br, input logic rdy);
        applyStimulus(name, exp, 5'd1, 5'd2, 1'b1, 1'b1, OPC_ALU, 5'd3,
                      br, 1'b1, rdy);
    endtask

    // Drop rst mid-cycle with idle inputs; outputs must change before any edge.
    task automatic assertResetMidCycle(input string name);
        @(posedge clk);
        #1;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_opcode   = OPC_ALU;
        ex_br_taken = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b0;
        rst         = 1'b0;
        pushExpect(name, E_RST);
    endtask

    task automatic releaseReset(input string name);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pushExpect(name, E_DEF);
    endtask

    initial begin
        rst         = 1'b0;
        id_rs1_num  = 5'd0;
        id_rs2_num  = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_opcode   = OPC_ALU;
        ex_rd_num   = 5'd0;
        ex_br_taken = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b0;

        @(posedge clk);
        #1;
        pushExpect("reset_state", E_RST);
        releaseReset("after_reset");

        // Load-use on rs1, then the load advances.
        applyStimulus("lu_rs1", E_LU, 5'd5, 5'd9, 1'b1, 1'b1, OPC_LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_rs1_clear", E_DEF, 5'd5, 5'd9, 1'b1, 1'b1, OPC_ALU, 5'd5, 1'b0, 1'b0, 1'b0);
        // rd = x0 never stalls.
        applyStimulus("lu_rd0", E_DEF, 5'd0, 5'd9, 1'b1, 1'b1, OPC_LOAD, 5'd0, 1'b0, 1'b0, 1'b0);
        // rs2 match, and rs2 match that the instruction does not read.
        applyStimulus("lu_rs2", E_LU, 5'd1, 5'd7, 1'b1, 1'b1, OPC_LOAD, 5'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus("lu_rs2_unused", E_DEF, 5'd1, 5'd7, 1'b1, 1'b0, OPC_LOAD, 5'd7, 1'b0, 1'b0, 1'b0);

        // Redirect with one extra flush cycle.
        applyStimulus("br_redirect", E_BR, 5'd1, 5'd2, 1'b1, 1'b1, OPC_BR, 5'd0, 1'b1, 1'b0, 1'b0);
        idleCycle("br_flush", E_FL);
        idleCycle("br_done", E_DEF);

        // Load-use pattern inside FLUSH is suppressed.
        applyStimulus("br2_redirect", E_BR, 5'd1, 5'd2, 1'b1, 1'b1, OPC_BR, 5'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("flush_lu_suppressed", E_FL, 5'd6, 5'd2, 1'b1, 1'b1, OPC_LOAD, 5'd6, 1'b0, 1'b0, 1'b0);
        idleCycle("br2_done", E_DEF);

        // Three memory wait cycles, then completion.
        memCycle("mw1", E_MW, 1'b0, 1'b0);
        memCycle("mw2", E_MW, 1'b0, 1'b0);
        memCycle("mw3", E_MW, 1'b0, 1'b0);
        memCycle("mw_ready", E_DEF, 1'b0, 1'b1);
        idleCycle("mw_after", E_DEF);

        // Branch during memory wait is held off until EX re-presents it.
        memCycle("br_mw_freeze", E_MW, 1'b1, 1'b0);
        memCycle("br_mw_ready", E_DEF, 1'b1, 1'b1);
        applyStimulus("br_mw_redirect", E_BR, 5'd1, 5'd2, 1'b1, 1'b1, OPC_BR, 5'd0, 1'b1, 1'b0, 1'b0);
        idleCycle("br_mw_flush", E_FL);
        idleCycle("br_mw_done", E_DEF);

        // Memory wait inside FLUSH preserves the pending flush cycle.
        applyStimulus("fl_mw_redirect", E_BR, 5'd1, 5'd2, 1'b1, 1'b1, OPC_BR, 5'd0, 1'b1, 1'b0, 1'b0);
        memCycle("fl_mw_freeze", E_MW, 1'b0, 1'b0);
        memCycle("fl_mw_ready", E_DEF, 1'b0, 1'b1);
        idleCycle("fl_mw_resume_flush", E_FL);
        idleCycle("fl_mw_done", E_DEF);

        // Watchdog: six wait cycles with MEM_TIMEOUT=4.
        memCycle("to_w1", E_MW, 1'b0, 1'b0);
        memCycle("to_w2", E_MW, 1'b0, 1'b0);
        memCycle("to_w3", E_MW, 1'b0, 1'b0);
        memCycle("to_w4", E_MW, 1'b0, 1'b0);
        memCycle("to_w5", E_MW_TO, 1'b0, 1'b0);
        memCycle("to_w6", E_MW_TO, 1'b0, 1'b0);
        memCycle("to_ready", E_DEF_TO, 1'b0, 1'b1);
        idleCycle("to_sticky", E_DEF_TO);
        assertResetMidCycle("to_async_clear");
        releaseReset("to_release");

        // Reset asserted while in FLUSH.
        applyStimulus("rf_redirect", E_BR, 5'd1, 5'd2, 1'b1, 1'b1, OPC_BR, 5'd0, 1'b1, 1'b0, 1'b0);
        assertResetMidCycle("rf_reset_in_flush");
        releaseReset("rf_release");
        idleCycle("rf_run", E_DEF);

        repeat (3) @(posedge clk);
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects three conditions and resolves them by stalling, bubbling or flushing: load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states.
- Includes a watchdog for memory handshakes that never complete.

Parameters:
- FLUSH_CYCLES, 1: extra cycles IF/ID flush is held after a redirect, covering instruction-memory latency; range 0..7.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before the timeout flag sets; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- i_id_rs1_num  in  5  rs1 index of the instruction in ID.
- i_id_rs2_num  in  5  rs2 index of the instruction in ID.
- i_id_uses_rs1  in  1  ID instruction reads rs1.
- i_id_uses_rs2  in  1  ID instruction reads rs2.
- i_ex_opcode  in  7  opcode held in ID/EX.
- i_ex_rd_num  in  5  rd held in ID/EX.
- i_ex_br_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- i_dmem_req  in  1  MEM stage is issuing a load/store.
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_pc_en  out  1  PC update enable.
- o_pc_sel  out  1  1 selects the EX branch target, 0 selects PC+4.
- o_if_id_en  out  1  IF/ID load enable.
- o_if_id_flush  out  1  IF/ID loads a NOP.
- o_id_ex_en  out  1  ID/EX load enable.
- o_id_ex_flush  out  1  ID/EX loads a bubble (opcode 0, rd 0).
- o_ex_mem_en  out  1  EX/MEM load enable.
- o_mem_wb_flush  out  1  MEM/WB loads a bubble.
- o_mem_timeout  out  1  sticky watchdog error.

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH. Reset state is RUN.
- Outputs are combinational from state and inputs. Counters and the FSM state are registered.
- While rst=0 (reset asserted):
  - all *_en outputs = 0;
  - o_if_id_flush = 1, o_id_ex_flush = 1, o_mem_wb_flush = 1;
  - o_pc_sel = 0, o_mem_timeout = 0;
  - flush counter = 0, wait counter = 0.
- Defaults, absent any hazard: all enables 1, all flushes 0, o_pc_sel = 0.
- Priority, highest first: memory wait, branch redirect, load-use.
- Memory wait (any state): i_dmem_req=1 and i_dmem_ready=0.
  - Outputs: o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en = 0; o_mem_wb_flush = 1. All other flushes 0 and o_pc_sel = 0, so a branch held in EX is not acted on.
  - Next state is MEM_WAIT. A pending FLUSH count is preserved.
- MEM_WAIT exit: i_dmem_ready=1.
  - That cycle produces the default outputs.
  - Next state is FLUSH if the flush counter is nonzero, else RUN.
  - The wait counter clears.
- Wait counter: increments each MEM_WAIT cycle and saturates. When it reaches MEM_TIMEOUT, o_mem_timeout sets and stays set until reset.
- Branch redirect: i_ex_br_taken=1 in RUN or FLUSH with no memory wait.
  - Outputs: o_pc_sel = 1, o_if_id_flush = 1, o_id_ex_flush = 1. Enables stay at defaults.
  - The flush counter loads FLUSH_CYCLES.
  - Next state is FLUSH if FLUSH_CYCLES > 0, else RUN.
  - A new redirect inside FLUSH reloads the counter.
- FLUSH state, no new redirect:
  - o_if_id_flush = 1; the counter decrements.
  - Return to RUN on the cycle the counter reaches 0.
  - Load-use detection is suppressed, because ID holds a NOP.
- Load-use hazard, RUN only, no higher-priority event. Condition: i_ex_opcode = 7'b0000011 and i_ex_rd_num != 0 and either
  - i_id_uses_rs1 and i_ex_rd_num = i_id_rs1_num, or
  - i_id_uses_rs2 and i_ex_rd_num = i_id_rs2_num.
  - Outputs: o_pc_en = 0, o_if_id_en = 0, o_id_ex_flush = 1, for exactly one cycle. The hazard clears on its own when the load advances.
- Reset mid-operation (rst=0 in any state): immediately forces the reset outputs above, with no clock required.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined: adds 32-bit outputs o_stall_cnt, o_flush_cnt and o_wait_cnt, reset to 0, wrapping.
  - o_stall_cnt increments on each load-use stall cycle.
  - o_flush_cnt increments on each redirect cycle.
  - o_wait_cnt increments on each MEM_WAIT cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load x5 in EX, ID uses rs1=5 -> one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; next cycle defaults. Repeat with rd=0 -> no stall.
- i_ex_br_taken=1 with FLUSH_CYCLES=1 -> cycle N: o_pc_sel=1, both flushes=1; cycle N+1: only o_if_id_flush=1; cycle N+2: defaults.
- i_dmem_req=1 with ready low for 3 cycles -> 3 cycles with all enables 0 and o_mem_wb_flush=1; ready cycle gives defaults; o_mem_timeout stays 0.
- Branch taken and memory wait in the same cycle -> memory freeze only, o_pc_sel=0; the redirect fires on the cycle ready=1 is followed by EX re-presenting the branch.
- MEM_TIMEOUT=4, ready held low for 6 cycles -> o_mem_timeout rises after the 4th wait cycle and stays high after ready; assert rst=0 -> clears asynchronously.
- rst asserted during FLUSH -> outputs immediately take reset values; after release, state RUN and defaults.
